spike_event_arbiter: RTL and testbench

- Collects on/off spike pulses from N_CH delta-modulator channels.
- Holds at most one pending event per channel and shares one output event port between channels with round-robin arbitration.
- Emits address-event words {channel, polarity, timestamp} through a small FIFO with a valid/ready handshake.
- Sits between the per-channel delta modulators and the chip output/serializer.

---
 rtl/spike_event_arbiter.sv | 121 ++++++++++++
 tb/tb_spike_event_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_arbiter.sv
// Spike event arbiter: captures per-channel on/off spikes, picks one pending channel per
// cycle round-robin, and queues {channel, polarity, timestamp} words in a small output FIFO.
module spike_event_arbiter #(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         spike_on,
  input  logic [N_CH-1:0]         spike_off,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_chan,
  output logic                    ev_pol,
  output logic [TS_W-1:0]         ev_ts,
  output logic [N_CH-1:0]         pending,
  output logic [7:0]              drop_cnt
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CH_W + 1 + TS_W;

  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  pol_q, pol_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [TS_W-1:0]  ts_q;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

  logic             found, grant_en, push, pop;
  logic [CH_W-1:0]  win, idx;
  logic [ENT_W-1:0] head;

  // Round-robin search: first pending channel at or above rr_q, wrapping modulo N_CH.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = rr_q + CH_W'(i);
      if (!found && pend_q[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Registered count only: a pop this cycle does not make room for this cycle's push.
  assign grant_en = found && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign push     = grant_en;
  assign pop      = ev_valid && ev_ready;
  assign rr_d     = grant_en ? win + CH_W'(1) : rr_q;

  // A new spike always lands in the pending slot; it only counts as a drop when it
  // replaces an event that is not leaving for the FIFO this cycle. On beats off.
  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    drop_d = drop_q;
    for (int c = 0; c < N_CH; c++) begin
      if (spike_on[c] || spike_off[c]) begin
        if (pend_q[c] && !(grant_en && win == CH_W'(c)) && drop_d != 8'hFF) begin
          drop_d = drop_d + 8'd1;
        end
        pend_d[c] = 1'b1;
        pol_d[c]  = spike_on[c];
      end else if (grant_en && win == CH_W'(c)) begin
        pend_d[c] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      pol_q  <= '0;
      rr_q   <= '0;
      ts_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      pend_q <= pend_d;
      pol_q  <= pol_d;
      rr_q   <= rr_d;
      ts_q   <= ts_q + TS_W'(1);
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_q] <= {win, pol_q[win], ts_q};
  end

  // Output handshake: ev_valid marks a head event; it is consumed at a clk edge where
  // ev_valid && ev_ready, and the head fields stay stable until then. Fields read 0 when empty.
  assign ev_valid = (cnt_q != '0);
  assign head     = ev_valid ? mem_q[rd_q] : '0;
  assign {ev_chan, ev_pol, ev_ts} = head;
  assign pending  = pend_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Self-checking bench for spike_event_arbiter: scenario tasks plus an event scoreboard.
module tb_spike_event_arbiter;

  localparam int N_CH = 4;
  localparam int TS_W = 8;
  localparam int CH_W = 2;
  localparam int EW   = CH_W + 1 + TS_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] spike_on, spike_off;
  logic            ev_valid, ev_ready, ev_pol;
  logic [CH_W-1:0] ev_chan;
  logic [TS_W-1:0] ev_ts;
  logic [N_CH-1:0] pending;
  logic [7:0]      drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   sb_e;
  logic [TS_W-1:0] tb_ts;

  spike_event_arbiter #(.N_CH(N_CH), .FIFO_DEPTH(4), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .spike_on(spike_on), .spike_off(spike_off),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan), .ev_pol(ev_pol),
    .ev_ts(ev_ts), .pending(pending), .drop_cnt(drop_cnt)
  );

  // ---- clock / reset / timestamp reference ----
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; spike_on = '0; spike_off = '0; ev_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  function automatic void expect_ev(input int ch, input logic pol, input int ts);
    exp_q.push_back({ch[CH_W-1:0], pol, ts[TS_W-1:0]});
  endfunction

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    ok = (exp_q.size() == 0);
    tick();
  endtask

  // ---- scoreboard: every accepted event is popped and compared ----
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got chan=%0d pol=%0d ts=%0d, expected no event",
                 ev_chan, ev_pol, ev_ts);
      end else begin
        sb_e = exp_q.pop_front();
        if ({ev_chan, ev_pol, ev_ts} !== sb_e)
          $display("FAIL sb_event: got chan=%0d pol=%0d ts=%0d, expected chan=%0d pol=%0d ts=%0d",
                   ev_chan, ev_pol, ev_ts, sb_e[EW-1 -: CH_W], sb_e[TS_W], sb_e[TS_W-1:0]);
        else n_pass++;
      end
    end
  end

  // ---- scenarios ----
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", ev_valid);
    else n_pass++;
    n_checks++;
    if (pending !== 4'b0000) $display("FAIL reset_pending: got %b, expected 0000", pending);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d, expected 0", drop_cnt);
    else n_pass++;
    n_checks++;
    if ({ev_chan, ev_pol, ev_ts} !== '0)
      $display("FAIL reset_head: got chan=%0d pol=%0d ts=%0d, expected all 0", ev_chan, ev_pol, ev_ts);
    else n_pass++;
  endtask

  task automatic test_single();
    int n = 0;
    apply_reset();
    while (tb_ts != 8'd10 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (tb_ts != 8'd10) $display("FAIL single_ts_wait: got ts=%0d, expected 10", tb_ts);
    else n_pass++;
    spike_on = 4'b0100;
    expect_ev(2, 1'b1, 11);
    tick();
    spike_on = '0;
    n_checks++;
    if (pending !== 4'b0100 || ev_valid !== 1'b0)
      $display("FAIL single_capture: got pending=%b valid=%b, expected 0100/0", pending, ev_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_chan !== 2'd2 || ev_pol !== 1'b1 || ev_ts !== 8'd11)
      $display("FAIL single_head: got valid=%b chan=%0d pol=%b ts=%0d, expected 1/2/1/11",
               ev_valid, ev_chan, ev_pol, ev_ts);
    else n_pass++;
    ev_ready = 1'b1;
    tick();
    n_checks++;
    if (ev_valid !== 1'b0) $display("FAIL single_pop: got valid=%b, expected 0", ev_valid);
    else n_pass++;
    ev_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int base;
    bit ok;
    apply_reset();
    ev_ready = 1'b1;
    base = int'(tb_ts);
    spike_off = 4'b1111;
    for (int k = 0; k < 4; k++) expect_ev(k, 1'b0, base + 1 + k);
    tick();
    spike_off = '0;
    n_checks++;
    if (pending !== 4'b1111) $display("FAIL rr_pending: got %b, expected 1111", pending);
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL rr_drain1: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    base = int'(tb_ts);
    spike_on = 4'b1010;
    expect_ev(1, 1'b1, base + 1);
    expect_ev(3, 1'b1, base + 2);
    tick();
    spike_on = '0;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL rr_drain2: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    ev_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int base;
    bit ok, moved;
    logic [EW-1:0] h0;
    apply_reset();
    base = int'(tb_ts);
    for (int c = 0; c < 4; c++) begin
      spike_on = '0;
      spike_on[c] = 1'b1;
      expect_ev(c, 1'b1, base + 1 + c);
      tick();
    end
    spike_on = 4'b0001;
    tick();
    spike_on = 4'b0001;
    tick();
    spike_on = '0;
    n_checks++;
    if (pending !== 4'b0001 || drop_cnt !== 8'd1)
      $display("FAIL bp_full: got pending=%b drop=%0d, expected 0001/1", pending, drop_cnt);
    else n_pass++;
    h0 = {ev_chan, ev_pol, ev_ts};
    n_checks++;
    if (ev_valid !== 1'b1 || h0 !== {2'd0, 1'b1, 8'(base + 1)})
      $display("FAIL bp_head: got valid=%b chan=%0d pol=%b ts=%0d, expected 1/0/1/%0d",
               ev_valid, ev_chan, ev_pol, ev_ts, 8'(base + 1));
    else n_pass++;
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({ev_chan, ev_pol, ev_ts} !== h0 || ev_valid !== 1'b1) moved = 1'b1;
    end
    n_checks++;
    if (moved || pending !== 4'b0001)
      $display("FAIL bp_stable: got moved=%b pending=%b, expected 0/0001", moved, pending);
    else n_pass++;
    expect_ev(0, 1'b1, int'(tb_ts) + 1);
    ev_ready = 1'b1;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL bp_drain: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    ev_ready = 1'b0;
  endtask

  task automatic test_collision();
    int base;
    bit ok;
    apply_reset();
    ev_ready = 1'b1;
    base = int'(tb_ts);
    spike_on = 4'b0001;
    expect_ev(0, 1'b1, base + 1);
    expect_ev(0, 1'b1, base + 2);
    tick();
    spike_on = 4'b0001;
    tick();
    spike_on = '0;
    n_checks++;
    if (pending[0] !== 1'b1 || drop_cnt !== 8'd0)
      $display("FAIL col_grant_edge: got pending0=%b drop=%0d, expected 1/0", pending[0], drop_cnt);
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok || drop_cnt !== 8'd0 || pending !== 4'b0000)
      $display("FAIL col_drain: got left=%0d drop=%0d pending=%b, expected 0/0/0000",
               exp_q.size(), drop_cnt, pending);
    else n_pass++;
    ev_ready = 1'b0;
  endtask

  task automatic test_overwrite();
    int base;
    bit ok;
    apply_reset();
    base = int'(tb_ts);
    spike_on  = 4'b0101;
    spike_off = 4'b1010;
    expect_ev(0, 1'b1, base + 1);
    expect_ev(1, 1'b0, base + 2);
    expect_ev(2, 1'b1, base + 3);
    expect_ev(3, 1'b0, base + 4);
    tick();
    spike_on = '0; spike_off = '0;
    for (int i = 0; i < 4; i++) tick();
    spike_on = 4'b0010;
    tick();
    spike_on = '0; spike_off = 4'b0010;
    tick();
    spike_off = '0;
    n_checks++;
    if (drop_cnt !== 8'd1 || pending !== 4'b0010)
      $display("FAIL ow_drop: got drop=%0d pending=%b, expected 1/0010", drop_cnt, pending);
    else n_pass++;
    spike_on = 4'b1000; spike_off = 4'b1000;
    tick();
    spike_on = '0; spike_off = '0;
    n_checks++;
    if (drop_cnt !== 8'd1 || pending !== 4'b1010)
      $display("FAIL ow_simul: got drop=%0d pending=%b, expected 1/1010", drop_cnt, pending);
    else n_pass++;
    expect_ev(1, 1'b0, int'(tb_ts) + 1);
    expect_ev(3, 1'b1, int'(tb_ts) + 2);
    ev_ready = 1'b1;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL ow_drain: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    ev_ready = 1'b0;
  endtask

  // Runs straight after test_overwrite so drop_cnt is non-zero going into the reset.
  task automatic test_reset_mid();
    int n = 0;
    bit ok;
    n_checks++;
    if (drop_cnt !== 8'd1) $display("FAIL rm_pre_drop: got %0d, expected 1", drop_cnt);
    else n_pass++;
    spike_on = 4'b0111;
    tick();
    spike_on = '0;
    for (int i = 0; i < 3; i++) tick();
    spike_on = 4'b0110;
    tick();
    spike_on = '0;
    n_checks++;
    if (pending !== 4'b0110 || ev_valid !== 1'b1)
      $display("FAIL rm_pre_state: got pending=%b valid=%b, expected 0110/1", pending, ev_valid);
    else n_pass++;
    rst_n = 1'b0; spike_on = 4'b1111; spike_off = 4'b1111;
    tick();
    rst_n = 1'b1; spike_on = '0; spike_off = '0;
    exp_q.delete();
    n_checks++;
    if (ev_valid !== 1'b0 || pending !== 4'b0000 || drop_cnt !== 8'd0)
      $display("FAIL rm_state: got valid=%b pending=%b drop=%0d, expected 0/0000/0",
               ev_valid, pending, drop_cnt);
    else n_pass++;
    n_checks++;
    if ({ev_chan, ev_pol, ev_ts} !== '0)
      $display("FAIL rm_head: got chan=%0d pol=%b ts=%0d, expected all 0", ev_chan, ev_pol, ev_ts);
    else n_pass++;
    spike_off = 4'b0100;
    expect_ev(2, 1'b0, 1);
    tick();
    spike_off = '0;
    ev_ready = 1'b1;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL rm_first: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    while (tb_ts != 8'd255 && n < 400) begin
      tick();
      n++;
    end
    spike_on = 4'b0001;
    expect_ev(0, 1'b1, 0);
    tick();
    spike_on = '0;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL rm_wrap: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    ev_ready = 1'b0;
  endtask

  // ---- sequence and report ----
  initial begin
    rst_n = 1'b0; spike_on = '0; spike_off = '0; ev_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_overwrite();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue: %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
